// File: rtl/axi_s_m_pktbuf.sv
// AXI4-Stream master with a store-and-forward packet FIFO; a whole packet is
// released once its last beat is buffered, or in cut-through when the FIFO fills.
module axi_s_m_pktbuf #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int CW    = 16
) (
   input  logic                     s_aclk,
   input  logic                     s_resetn,
   input  logic                     wr_en,
   input  logic [DW-1:0]            wr_data,
   input  logic                     wr_last,
   output logic                     wr_full,
   output logic                     overflow,
   output logic                     m_tvalid,
   output logic [DW-1:0]            m_tdata,
   output logic                     m_tlast,
   input  logic                     m_tready,
   output logic [$clog2(DEPTH):0]   pkts_pending,
   output logic [CW-1:0]            pkts_sent
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   pend_q, pend_d;
   logic [CW-1:0] sent_q, sent_d;
   logic          ovf_q, ovf_d;
   logic [0:0]    state_q, state_d;

   logic          push, pop, pop_last, push_last;
   logic [DW:0]   head;

   assign head      = mem_q[rd_ptr_q];
   assign wr_full   = (count_q == FULL_CNT);
   assign m_tvalid  = (state_q == SEND) && (count_q != '0);
   assign m_tdata   = m_tvalid ? head[DW-1:0] : '0;
   assign m_tlast   = m_tvalid & head[DW];
   assign overflow  = ovf_q;
   assign pkts_pending = pend_q;
   assign pkts_sent = sent_q;

   // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
   assign push      = wr_en & ~wr_full;
   assign pop       = m_tvalid & m_tready;
   assign pop_last  = pop & head[DW];
   assign push_last = push & wr_last;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pend_d   = pend_q;
      sent_d   = sent_q;
      ovf_d    = ovf_q;
      state_d  = state_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      case ({push_last, pop_last})
         2'b10:   pend_d = pend_q + (AW+1)'(1);
         2'b01:   pend_d = pend_q - (AW+1)'(1);
         default: pend_d = pend_q;
      endcase

      if (pop_last)         sent_d = sent_q + CW'(1);
      if (wr_en && wr_full) ovf_d  = 1'b1;

      // Full FIFO with no complete packet means a packet longer than DEPTH: stream it.
      case (state_q)
         IDLE:    if ((pend_q != '0) || wr_full) state_d = SEND;
         SEND:    if (pop_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge s_aclk) begin
      if (!s_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_q   <= '0;
         sent_q   <= '0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         sent_q   <= sent_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
      end
   end

   always_ff @(posedge s_aclk) begin
      if (push) mem_q[wr_ptr_q] <= {wr_last, wr_data};
   end

endmodule

// File: tb/tb_axi_s_m_pktbuf.sv
// Randomized and directed bench for axi_s_m_pktbuf against a queue-based packet model.
module tb_axi_s_m_pktbuf;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          s_aclk = 1'b0;
   logic          s_resetn = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_last = 1'b0;
   logic          wr_full, overflow, m_tvalid, m_tlast;
   logic [DW-1:0] m_tdata;
   logic          m_tready = 1'b0;
   logic [AW:0]   pkts_pending;
   logic [CW-1:0] pkts_sent;

   always #5 s_aclk = ~s_aclk;

   axi_s_m_pktbuf #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .s_aclk(s_aclk), .s_resetn(s_resetn),
      .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
      .wr_full(wr_full), .overflow(overflow),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
      .pkts_pending(pkts_pending), .pkts_sent(pkts_sent)
   );

   // Model: buffered {last,data} entries, whether a packet is being released, counters.
   logic [DW:0] q[$];
   bit          sending = 0;
   int          sent = 0;
   bit          ovf = 0;
   bit          chk_on = 0;
   int          total = 0;
   int          bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int n_lasts();
      int n = 0;
      foreach (q[i]) if (q[i][DW]) n++;
      return n;
   endfunction

   // One clock: check outputs at the falling edge, drive inputs, advance the model.
   task automatic step(input logic we, input logic [DW-1:0] d, input logic wl,
                       input logic rdy, input logic rn);
      bit vld, full, pop, plast, start;
      @(negedge s_aclk);
      vld  = sending && (q.size() != 0);
      full = (q.size() == DEPTH);
      if (chk_on) begin
         check_val("m_tvalid", 32'(m_tvalid), 32'(vld));
         check_val("m_tdata", 32'(m_tdata), vld ? 32'(q[0][DW-1:0]) : 32'd0);
         check_val("m_tlast", 32'(m_tlast), vld ? 32'(q[0][DW]) : 32'd0);
         check_val("wr_full", 32'(wr_full), 32'(full));
         check_val("overflow", 32'(overflow), 32'(ovf));
         check_val("pkts_pending", 32'(pkts_pending), 32'(n_lasts()));
         check_val("pkts_sent", 32'(pkts_sent), sent & 32'hFFFF);
      end
      wr_en = we; wr_data = d; wr_last = wl; m_tready = rdy; s_resetn = rn;
      if (!rn) begin
         q.delete(); sending = 0; sent = 0; ovf = 0;
      end else begin
         pop   = vld && rdy;
         plast = pop && q[0][DW];
         start = !sending && ((n_lasts() > 0) || full);
         if (pop) void'(q.pop_front());
         if (we) begin
            if (full) ovf = 1;
            else q.push_back({wl, d});
         end
         if (plast) begin
            sent++;
            sending = 0;
         end else if (start) begin
            sending = 1;
         end
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(0, '0, 0, rdy, 1);
   endtask

   task automatic rnd(input int n, input int wr_pct, input int mode);
      logic rdy;
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       rdy = 1'($urandom_range(1));
            1:       rdy = 1'b1;
            default: rdy = (i % 3 == 0);
         endcase
         step(($urandom_range(99) < wr_pct), DW'($urandom), ($urandom_range(3) == 0), rdy, 1);
      end
   endtask

   initial begin
      int lat;
      step(0, '0, 0, 0, 0);
      chk_on = 1;
      step(0, '0, 0, 0, 0);
      idle(2, 1);

      // 4-beat packet, ready high, latency from last push to valid
      for (int i = 0; i < 4; i++) step(1, DW'(8'hA0 + i), (i == 3), 1, 1);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, '0, 0, 1, 1);
         lat++;
         if (m_tvalid) break;
      end
      check_val("latency", 32'(lat), 32'd2);
      idle(8, 1);
      check_val("sent_after_A", 32'(pkts_sent), 32'd1);

      // same packet under stalling ready pattern 1,0,0
      for (int i = 0; i < 4; i++) step(1, DW'(8'hB0 + i), (i == 3), (i % 3 == 0), 1);
      for (int i = 0; i < 20; i++) step(0, '0, 0, (i % 3 == 0), 1);

      // partial packet held until its last beat arrives
      for (int i = 0; i < 3; i++) step(1, DW'(8'hC0 + i), 0, 1, 1);
      idle(5, 1);
      check_val("partial_hold", 32'(m_tvalid), 32'd0);
      step(1, 8'hC3, 1, 1, 1);
      idle(10, 1);

      // overflow: 17 pushes with ready low, then cut-through drain
      for (int i = 0; i < 17; i++) step(1, DW'(8'hD0 + i), 0, 0, 1);
      idle(2, 0);
      check_val("ovf_set", 32'(overflow), 32'd1);
      idle(22, 1);
      step(1, 8'hEE, 1, 1, 1);
      idle(6, 1);

      // back-to-back packets of length 1, 2 and 5
      for (int i = 0; i < 8; i++) step(1, DW'(8'h10 + i), (i == 0 || i == 2 || i == 7), 1, 1);
      idle(20, 1);

      // reset in the middle of a 5-beat packet after two beats are sent
      for (int i = 0; i < 5; i++) step(1, DW'(8'h50 + i), (i == 4), 0, 1);
      idle(2, 0);
      idle(2, 1);
      step(0, '0, 0, 0, 0);
      idle(10, 1);
      check_val("pend_after_rst", 32'(pkts_pending), 32'd0);
      check_val("sent_after_rst", 32'(pkts_sent), 32'd0);

      // randomized traffic with mixed ready behaviour
      rnd(600, 60, 0);
      rnd(400, 90, 2);
      rnd(400, 40, 1);
      rnd(300, 95, 0);
      idle(40, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
